// File: rtl/arb_req4.sv
// Requester-side agent for a 4-line rotating-priority arbiter: queues per-line
// transactions, drives req/en, retires grants and polices the grant stream.
module arb_req4 #(
    parameter int CNT_W      = 3,
    parameter int STARVE_LIM = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [3:0]           push,
    input  logic                 hold,
    input  logic                 clr_err,
    input  logic [3:0]           gnt,
    output logic [3:0]           req,
    output logic                 en,
    output logic [3:0]           done,
    output logic [4*CNT_W-1:0]   pend,
    output logic [3:0]           full,
    output logic [3:0]           overflow,
    output logic                 err_multi,
    output logic                 err_spur,
    output logic [3:0]           starve,
    output logic [15:0]          gnt_total
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [3:0]       WAIT_MAX = 4'hF;
    localparam logic [3:0]       LIM      = 4'(STARVE_LIM);

    logic [CNT_W-1:0] cnt_q  [4];
    logic [CNT_W-1:0] cnt_d  [4];
    logic [3:0]       wait_q [4];
    logic [3:0]       wait_d [4];

    logic       gnt_onehot;
    logic       gnt_multi;
    logic       spur_hit;
    logic [3:0] valid_g;
    logic [3:0] ovf_hit;
    logic [3:0] starve_hit;

    // req/en/full/pend come from registers only; gnt never feeds back into them
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req[i]                  = (cnt_q[i] != '0);
            full[i]                 = (cnt_q[i] == CNT_MAX);
            pend[i*CNT_W +: CNT_W]  = cnt_q[i];
        end
    end

    assign en = (|req) & ~hold;

    always_comb begin
        gnt_onehot = (gnt != 4'd0) && ((gnt & (gnt - 4'd1)) == 4'd0);
        gnt_multi  = (gnt != 4'd0) && !gnt_onehot;
        spur_hit   = (|(gnt & ~req)) || ((gnt != 4'd0) && !en);
        valid_g    = (gnt_onehot && en && ((req & gnt) != 4'd0)) ? gnt : 4'd0;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_d[i]   = cnt_q[i];
            ovf_hit[i] = 1'b0;
            if (push[i] && !valid_g[i]) begin
                if (full[i]) ovf_hit[i] = 1'b1;
                else         cnt_d[i]   = cnt_q[i] + 1'b1;
            end else if (valid_g[i] && !push[i]) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end

            // paused cycles (en low) neither count nor clear
            if (!req[i] || valid_g[i])
                wait_d[i] = 4'd0;
            else if (en && (wait_q[i] != WAIT_MAX))
                wait_d[i] = wait_q[i] + 4'd1;
            else
                wait_d[i] = wait_q[i];

            starve_hit[i] = (wait_d[i] == LIM);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i]  <= '0;
                wait_q[i] <= 4'd0;
            end
            done      <= 4'd0;
            overflow  <= 4'd0;
            err_multi <= 1'b0;
            err_spur  <= 1'b0;
            starve    <= 4'd0;
            gnt_total <= 16'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i]  <= cnt_d[i];
                wait_q[i] <= wait_d[i];
            end
            done      <= valid_g;
            overflow  <= (clr_err ? 4'd0 : overflow) | ovf_hit;
            err_multi <= (err_multi & ~clr_err) | gnt_multi;
            err_spur  <= (err_spur & ~clr_err) | spur_hit;
            starve    <= (clr_err ? 4'd0 : starve) | starve_hit;
            if (valid_g != 4'd0)
                gnt_total <= gnt_total + 16'd1;
        end
    end

endmodule

// File: tb/tb_arb_req4.sv
// Bench for arb_req4: directed scenarios plus randomized traffic against a
// transaction-level reference model.
module tb_arb_req4;

    localparam int LIM  = 6;
    localparam int MAXP = 7;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  push = 4'd0;
    logic        hold = 1'b0;
    logic        clr_err = 1'b0;
    logic [3:0]  gnt = 4'd0;
    logic [3:0]  req;
    logic        en;
    logic [3:0]  done;
    logic [11:0] pend;
    logic [3:0]  full;
    logic [3:0]  overflow;
    logic        err_multi;
    logic        err_spur;
    logic [3:0]  starve;
    logic [15:0] gnt_total;

    int n_tests = 0;
    int n_fail  = 0;

    arb_req4 #(.CNT_W(3), .STARVE_LIM(LIM)) dut (
        .clock(clock), .reset(reset), .push(push), .hold(hold), .clr_err(clr_err),
        .gnt(gnt), .req(req), .en(en), .done(done), .pend(pend), .full(full),
        .overflow(overflow), .err_multi(err_multi), .err_spur(err_spur),
        .starve(starve), .gnt_total(gnt_total)
    );

    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- reference model (transaction level) ----------------
    int m_pend [4];
    int m_wait [4];
    bit m_done [4];
    bit m_ovf  [4];
    bit m_starve [4];
    bit m_multi, m_spur;
    int m_total;

    logic [3:0]  e_req, e_done, e_full, e_ovf, e_starve;
    logic        e_en, e_multi, e_spur;
    logic [11:0] e_pend;
    logic [15:0] e_total;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_pend[i] = 0; m_wait[i] = 0; m_done[i] = 0; m_ovf[i] = 0; m_starve[i] = 0;
        end
        m_multi = 0; m_spur = 0; m_total = 0;
    endtask

    task automatic model_step();
        bit rq [4];
        bit en_m;
        int nb;
        int win;
        bit spur;
        en_m = 0;
        for (int i = 0; i < 4; i++) begin
            rq[i] = (m_pend[i] > 0);
            en_m  = en_m | rq[i];
        end
        en_m = en_m && !hold;
        nb = $countones(gnt);
        win = -1;
        if (nb == 1 && en_m)
            for (int i = 0; i < 4; i++) if (gnt[i] && rq[i]) win = i;
        spur = 0;
        for (int i = 0; i < 4; i++) if (gnt[i] && (!rq[i] || !en_m)) spur = 1;
        if (clr_err) begin
            m_multi = 0; m_spur = 0;
            for (int i = 0; i < 4; i++) begin m_ovf[i] = 0; m_starve[i] = 0; end
        end
        if (nb > 1) m_multi = 1;
        if (spur) m_spur = 1;
        for (int i = 0; i < 4; i++) begin
            bit g;
            g = (win == i);
            if (!rq[i] || g) m_wait[i] = 0;
            else if (en_m && m_wait[i] < 15) m_wait[i]++;
            if (m_wait[i] == LIM) m_starve[i] = 1;
            if (push[i] && !g) begin
                if (m_pend[i] < MAXP) m_pend[i]++;
                else m_ovf[i] = 1;
            end else if (g && !push[i]) begin
                m_pend[i]--;
            end
            m_done[i] = g;
        end
        if (win >= 0) m_total = (m_total + 1) % 65536;
    endtask

    task automatic model_vecs();
        for (int i = 0; i < 4; i++) begin
            e_req[i]    = (m_pend[i] > 0);
            e_done[i]   = m_done[i];
            e_full[i]   = (m_pend[i] == MAXP);
            e_ovf[i]    = m_ovf[i];
            e_starve[i] = m_starve[i];
            e_pend[i*3 +: 3] = 3'(m_pend[i]);
        end
        e_en    = (|e_req) & ~hold;
        e_multi = m_multi;
        e_spur  = m_spur;
        e_total = 16'(m_total);
    endtask

    task automatic drive(input logic [3:0] p, input logic [3:0] g, input logic h, input logic c);
        push = p; gnt = g; hold = h; clr_err = c;
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        model_vecs();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        #12;
        n_tests++; if ({req, en, done, full} !== 13'd0) begin n_fail++; $display("FAIL reset_ctl: got %h expected 0", {req, en, done, full}); end
        n_tests++; if ({overflow, err_multi, err_spur, starve} !== 10'd0) begin n_fail++; $display("FAIL reset_flags: got %h expected 0", {overflow, err_multi, err_spur, starve}); end
        n_tests++; if (pend !== 12'd0) begin n_fail++; $display("FAIL reset_pend: got %h expected 0", pend); end
        n_tests++; if (gnt_total !== 16'd0) begin n_fail++; $display("FAIL reset_total: got %0d expected 0", gnt_total); end
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        drive(4'b0001, 4'b0000, 0, 0); tick();
        drive(4'b0000, 4'b0000, 0, 0);
        n_tests++; if (req !== 4'b0001) begin n_fail++; $display("FAIL single_req: got %b expected 0001", req); end
        n_tests++; if (en !== 1'b1) begin n_fail++; $display("FAIL single_en: got %b expected 1", en); end
        n_tests++; if (pend[2:0] !== 3'd1) begin n_fail++; $display("FAIL single_pend1: got %0d expected 1", pend[2:0]); end
        drive(4'b0000, 4'b0001, 0, 0); tick();
        drive(4'b0000, 4'b0000, 0, 0);
        n_tests++; if (done !== 4'b0001) begin n_fail++; $display("FAIL single_done: got %b expected 0001", done); end
        n_tests++; if (pend[2:0] !== 3'd0) begin n_fail++; $display("FAIL single_pend0: got %0d expected 0", pend[2:0]); end
        n_tests++; if (req !== 4'b0000) begin n_fail++; $display("FAIL single_req_drop: got %b expected 0000", req); end
        n_tests++; if (gnt_total !== 16'd1) begin n_fail++; $display("FAIL single_total: got %0d expected 1", gnt_total); end
        tick();
        n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL single_done_pulse: got %b expected 0000", done); end
    endtask

    task automatic test_fill_overflow();
        for (int k = 0; k < 7; k++) begin drive(4'b0100, 4'b0000, 0, 0); tick(); end
        n_tests++; if (pend[8:6] !== 3'd7) begin n_fail++; $display("FAIL fill_pend: got %0d expected 7", pend[8:6]); end
        n_tests++; if (full !== 4'b0100) begin n_fail++; $display("FAIL fill_full: got %b expected 0100", full); end
        n_tests++; if (overflow !== 4'b0000) begin n_fail++; $display("FAIL fill_no_ovf: got %b expected 0000", overflow); end
        tick();
        n_tests++; if (pend[8:6] !== 3'd7) begin n_fail++; $display("FAIL ovf_pend: got %0d expected 7", pend[8:6]); end
        n_tests++; if (overflow !== 4'b0100) begin n_fail++; $display("FAIL ovf_flag: got %b expected 0100", overflow); end
        drive(4'b0000, 4'b0000, 0, 1); tick();
        n_tests++; if (overflow !== 4'b0000) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0000", overflow); end
        drive(4'b0100, 4'b0100, 0, 0); tick();
        n_tests++; if (pend[8:6] !== 3'd7) begin n_fail++; $display("FAIL pushgnt_pend: got %0d expected 7", pend[8:6]); end
        n_tests++; if (overflow !== 4'b0000) begin n_fail++; $display("FAIL pushgnt_ovf: got %b expected 0000", overflow); end
        n_tests++; if (done !== 4'b0100) begin n_fail++; $display("FAIL pushgnt_done: got %b expected 0100", done); end
        n_tests++; if (full !== 4'b0100) begin n_fail++; $display("FAIL pushgnt_full: got %b expected 0100", full); end
        drive(4'b0000, 4'b0100, 0, 0);
        for (int k = 0; k < 7; k++) tick();
        drive(4'b0000, 4'b0000, 0, 0);
        n_tests++; if (pend !== 12'd0) begin n_fail++; $display("FAIL drain_pend: got %h expected 0", pend); end
        n_tests++; if (gnt_total !== e_total) begin n_fail++; $display("FAIL drain_total: got %0d expected %0d", gnt_total, e_total); end
    endtask

    task automatic test_multi_hot();
        drive(4'b0000, 4'b0000, 0, 1); tick();
        drive(4'b0011, 4'b0000, 0, 0); tick();
        drive(4'b0000, 4'b0011, 0, 0); tick();
        drive(4'b0000, 4'b0000, 0, 0);
        n_tests++; if (err_multi !== 1'b1) begin n_fail++; $display("FAIL multi_err: got %b expected 1", err_multi); end
        n_tests++; if (pend !== 12'o0011) begin n_fail++; $display("FAIL multi_pend: got %o expected 0011", pend); end
        n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL multi_done: got %b expected 0000", done); end
        n_tests++; if (gnt_total !== e_total) begin n_fail++; $display("FAIL multi_total: got %0d expected %0d", gnt_total, e_total); end
        drive(4'b0000, 4'b0001, 0, 0); tick();
        drive(4'b0000, 4'b0010, 0, 0); tick();
        drive(4'b0000, 4'b0000, 0, 0);
        n_tests++; if (pend !== 12'd0) begin n_fail++; $display("FAIL multi_drain: got %o expected 0", pend); end
    endtask

    task automatic test_spurious();
        drive(4'b0000, 4'b0000, 0, 1); tick();
        drive(4'b0000, 4'b1000, 0, 0); tick();
        drive(4'b0000, 4'b0000, 0, 0);
        n_tests++; if (err_spur !== 1'b1) begin n_fail++; $display("FAIL spur_idle: got %b expected 1", err_spur); end
        n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL spur_idle_done: got %b expected 0000", done); end
        drive(4'b0010, 4'b0000, 0, 1); tick();
        n_tests++; if (err_spur !== 1'b0) begin n_fail++; $display("FAIL spur_clr: got %b expected 0", err_spur); end
        drive(4'b0000, 4'b0000, 1, 0);
        #1;
        n_tests++; if (en !== 1'b0) begin n_fail++; $display("FAIL hold_en: got %b expected 0", en); end
        drive(4'b0000, 4'b0010, 1, 0); tick();
        drive(4'b0000, 4'b0000, 0, 0);
        n_tests++; if (err_spur !== 1'b1) begin n_fail++; $display("FAIL spur_hold: got %b expected 1", err_spur); end
        n_tests++; if (pend[5:3] !== 3'd1) begin n_fail++; $display("FAIL spur_hold_pend: got %0d expected 1", pend[5:3]); end
        n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL spur_hold_done: got %b expected 0000", done); end
        drive(4'b0000, 4'b0010, 0, 0); tick();
        drive(4'b0000, 4'b0000, 0, 0);
        n_tests++; if (done !== 4'b0010) begin n_fail++; $display("FAIL spur_after_done: got %b expected 0010", done); end
    endtask

    task automatic test_starvation();
        drive(4'b0000, 4'b0000, 0, 1); tick();
        drive(4'b1000, 4'b0000, 0, 0); tick();
        drive(4'b0000, 4'b0000, 0, 0);
        for (int k = 0; k < 5; k++) tick();
        n_tests++; if (starve !== 4'b0000) begin n_fail++; $display("FAIL starve_early: got %b expected 0000", starve); end
        tick();
        n_tests++; if (starve !== 4'b1000) begin n_fail++; $display("FAIL starve_set: got %b expected 1000", starve); end
        drive(4'b0000, 4'b1000, 0, 0); tick();
        drive(4'b0000, 4'b0000, 0, 1); tick();
        drive(4'b1000, 4'b0000, 0, 0); tick();
        drive(4'b0000, 4'b0000, 1, 0);
        for (int k = 0; k < 10; k++) begin
            tick();
            n_tests++; if (starve !== 4'b0000) begin n_fail++; $display("FAIL starve_hold cyc %0d: got %b expected 0000", k, starve); end
        end
        drive(4'b0000, 4'b0000, 0, 0);
        for (int k = 0; k < 5; k++) tick();
        drive(4'b0000, 4'b0100, 0, 0); tick();
        drive(4'b0000, 4'b0000, 0, 0);
        n_tests++; if ({starve, err_spur} !== 5'b10001) begin n_fail++; $display("FAIL starve_resume: got %b expected 10001", {starve, err_spur}); end
        drive(4'b0000, 4'b0000, 0, 1); tick();
        drive(4'b0000, 4'b0000, 0, 0);
        n_tests++; if ({overflow, err_multi, err_spur, starve} !== 10'd0) begin n_fail++; $display("FAIL clr_all: got %b expected 0", {overflow, err_multi, err_spur, starve}); end
        drive(4'b0000, 4'b1000, 0, 0); tick();
        drive(4'b0000, 4'b0000, 0, 0);
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 3; k++) begin drive(4'b0001, 4'b0000, 0, 0); tick(); end
        drive(4'b0000, 4'b0001, 0, 0);
        n_tests++; if (pend[2:0] !== 3'd3) begin n_fail++; $display("FAIL arst_pre_pend: got %0d expected 3", pend[2:0]); end
        #3;
        reset = 1'b0;
        #1;
        n_tests++; if (req !== 4'b0000) begin n_fail++; $display("FAIL arst_req: got %b expected 0000", req); end
        n_tests++; if (pend !== 12'd0) begin n_fail++; $display("FAIL arst_pend: got %h expected 0", pend); end
        n_tests++; if (gnt_total !== 16'd0) begin n_fail++; $display("FAIL arst_total: got %0d expected 0", gnt_total); end
        n_tests++; if (en !== 1'b0) begin n_fail++; $display("FAIL arst_en: got %b expected 0", en); end
        gnt = 4'b0000;
        for (int k = 0; k < 2; k++) begin
            @(posedge clock); #1;
            n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL arst_done cyc %0d: got %b expected 0000", k, done); end
        end
        #3;
        reset = 1'b1;
        model_reset();
        tick();
        n_tests++; if ({done, req, pend} !== 20'd0) begin n_fail++; $display("FAIL arst_release: got %h expected 0", {done, req, pend}); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            logic [3:0] p;
            logic [3:0] g;
            int sel;
            int lines[$];
            p = 4'($urandom) & 4'($urandom);
            sel = $urandom_range(0, 9);
            g = 4'd0;
            if (sel < 6) begin
                lines = {};
                for (int i = 0; i < 4; i++) if (m_pend[i] > 0) lines.push_back(i);
                if (lines.size() > 0) g[lines[$urandom_range(0, lines.size() - 1)]] = 1'b1;
            end else if (sel == 6) begin
                g = 4'($urandom);
                if ($countones(g) > 1) p = 4'd0;
            end
            drive(p, g, ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
            tick();
            n_tests++; if (req !== e_req) begin n_fail++; $display("FAIL rnd_req cyc %0d: got %b expected %b", c, req, e_req); end
            n_tests++; if (en !== e_en) begin n_fail++; $display("FAIL rnd_en cyc %0d: got %b expected %b", c, en, e_en); end
            n_tests++; if (done !== e_done) begin n_fail++; $display("FAIL rnd_done cyc %0d: got %b expected %b", c, done, e_done); end
            n_tests++; if (pend !== e_pend) begin n_fail++; $display("FAIL rnd_pend cyc %0d: got %o expected %o", c, pend, e_pend); end
            n_tests++; if (full !== e_full) begin n_fail++; $display("FAIL rnd_full cyc %0d: got %b expected %b", c, full, e_full); end
            n_tests++; if (overflow !== e_ovf) begin n_fail++; $display("FAIL rnd_ovf cyc %0d: got %b expected %b", c, overflow, e_ovf); end
            n_tests++; if (err_multi !== e_multi) begin n_fail++; $display("FAIL rnd_multi cyc %0d: got %b expected %b", c, err_multi, e_multi); end
            n_tests++; if (err_spur !== e_spur) begin n_fail++; $display("FAIL rnd_spur cyc %0d: got %b expected %b", c, err_spur, e_spur); end
            n_tests++; if (starve !== e_starve) begin n_fail++; $display("FAIL rnd_starve cyc %0d: got %b expected %b", c, starve, e_starve); end
            n_tests++; if (gnt_total !== e_total) begin n_fail++; $display("FAIL rnd_total cyc %0d: got %0d expected %0d", c, gnt_total, e_total); end
        end
        drive(4'b0000, 4'b0000, 0, 0);
    endtask

    initial begin
        model_reset();
        model_vecs();
        test_reset();
        test_single();
        test_fill_overflow();
        test_multi_hot();
        test_spurious();
        test_starvation();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/arb_req4.md
# arb_req4

Requester-side agent for the 4-line rotating-priority grant interface. It queues per-line transaction requests, drives the arbiter's `req`/`en` lines, and consumes the returned one-hot `gnt`. Each grant retires one pending transaction. The block also polices the grant stream for protocol violations and starvation. It sits between client logic and the 4-line arbiter; its `gnt` input comes straight from the arbiter's combinational grant output.

## Interface
- `CNT_W`, 3: width of each per-line pending counter; capacity is 2^CNT_W-1 transactions per line.
- `STARVE_LIM`, 6: consecutive ungranted requesting-and-enabled cycles after which a line is flagged starved; legal range 1..15.
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `push`  in  4: per-line "enqueue one transaction" strobe, sampled each rising edge.
- `hold`  in  1: when high, forces `en` low (arbitration paused).
- `clr_err`  in  1: synchronous clear of all sticky flags.
- `gnt`  in  4: grant from arbiter, expected one-hot or zero.
- `req`  out  4: `req[i]` = pending counter i nonzero.
- `en`  out  1: `(|req) & ~hold`.
- `done`  out  4: registered one-cycle pulse, one cycle after line i's grant is consumed.
- `pend`  out  4*CNT_W: pending counters; line i is at bits [i*CNT_W +: CNT_W].
- `full`  out  4: counter i at max (2^CNT_W-1).
- `overflow`  out  4: sticky; a push arrived while line i was full and could not be absorbed.
- `err_multi`  out  1: sticky; `gnt` had more than one bit set.
- `err_spur`  out  1: sticky; a grant arrived on a line whose `req` was low, or while `en` was low.
- `starve`  out  4: sticky; line i's wait counter reached `STARVE_LIM`.
- `gnt_total`  out  16: count of consumed grants; wraps at 65535 -> 0.

## Operation
- `req` and `en` are pure functions of registers and `hold`. There is no combinational path from `gnt` to `req` or `en`.
- Grant validity each cycle: `valid_g = gnt` if `gnt` is one-hot and `en`=1 and `req & gnt` != 0; otherwise `valid_g` = 0.
- Pending counter i, next value:
  - +1 when `push[i]` and not `valid_g[i]` and not full.
  - -1 when `valid_g[i]` and not `push[i]`.
  - Unchanged when `push[i]` and `valid_g[i]` are both set; this applies even when the line is full, and no overflow is flagged.
  - Unchanged, with `overflow[i]` set, when `push[i]` arrives while full and there is no grant.
- Multi-hot `gnt`: nothing is consumed, no counter changes, `err_multi` set.
- Spurious grant (a `gnt` bit with `req` low, or any `gnt` while `en`=0): that bit is ignored and `err_spur` set. In a single-hot case the other lines are unaffected.
- `done` next = `valid_g`. `gnt_total` increments by 1 on any nonzero `valid_g`.
- Wait counter i (4 bits, saturating at 15):
  - Cleared when `req[i]`=0 or `valid_g[i]`.
  - Otherwise increments when `req[i]` & `en`.
  - Holds when `en`=0 (pause does not count).
  - `starve[i]` set when the wait counter equals `STARVE_LIM`.
- `clr_err` clears `overflow`, `err_multi`, `err_spur` and `starve`. A new error in the same cycle takes priority: the flag reads 1 next cycle.

## Timing
- Reset (`reset`=0, asynchronous) values: all counters 0, wait counters 0, `req`=0, `en`=0, `done`=0, `full`=0, all sticky flags 0, `gnt_total`=0.
- On release of reset, the first active edge is the first rising `clock` with `reset`=1.
- Push-to-req latency is one cycle: `push[i]` at edge N gives `req[i]`=1 after edge N.
- A grant sampled at edge N:
  - decrements the counter after N;
  - raises `done[i]` for the cycle after N;
  - drops `req[i]` after N if this was the last pending transaction.
- Reset asserted mid-operation discards all pending transactions immediately. No `done` pulses are emitted for them.
- `full` and `pend` are registered values; `full` updates the same cycle `pend` does.

## Test plan
- Reset then a single push: `push`=0001 for one cycle -> `req`=0001, `en`=1. Drive `gnt`=0001 -> next cycle `done`=0001, `pend[0]`=0, `req`=0, `gnt_total`=1.
- Fill and overflow with `CNT_W`=3: 7 pushes on line 2 -> `full[2]`=1, `pend[2]`=7. An 8th push with no grant -> `pend[2]` stays 7, `overflow[2]`=1. Push plus grant on the same line while full -> `pend[2]`=7, no new overflow.
- Multi-hot grant: lines 0 and 1 pending, `gnt`=0011 -> `err_multi`=1, `pend` unchanged, `done`=0, `gnt_total` unchanged.
- Spurious grant: `pend` all 0, `gnt`=1000 -> `err_spur`=1. Also `hold`=1 with line 1 pending and `gnt`=0010 -> `err_spur`=1 and `pend[1]` unchanged.
- Starvation: line 3 pending, `en`=1, `gnt`=0 for 6 cycles -> `starve[3]`=1 on the 7th cycle. Repeat with `hold`=1 for 10 cycles -> `starve` stays 0. Then `clr_err` -> all sticky flags 0.
- Async reset mid-stream: 3 pending on line 0, drop `reset` between edges -> `req`, `pend` and `gnt_total` read 0 immediately, and no `done` pulse follows.
